// File: rtl/projector_pkg.sv
// Types and helpers shared between the projector lanes and the triangle stream merger.
package projector_pkg;

   localparam int TRI_W_DEFAULT = 128;

   typedef logic [TRI_W_DEFAULT-1:0] triangle_t;

   function automatic int next_lane(input int lane, input int n_lanes);
      return (lane + 1) % n_lanes;
   endfunction

endpackage

// File: rtl/triangle_fifo.sv
// Per-lane triangle FIFO: register array with a registered head word (dout).
// Pointers carry one extra wrap bit so full and empty can be told apart.
module triangle_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic [AW:0]      rptr_next;
   logic             do_push;
   logic             do_pop;

   assign empty     = (wptr == rptr);
   assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign rptr_next = rptr + (AW+1)'(do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr[AW-1:0]] <= din;
      end
   end

   // dout always holds the word at the next head; a push into the head slot is forwarded from din.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr <= '0;
         rptr <= '0;
         dout <= '0;
      end else begin
         if (do_push) begin
            wptr <= wptr + (AW+1)'(1);
         end
         rptr <= rptr_next;
         if (do_push && (wptr == rptr_next)) begin
            dout <= din;
         end else begin
            dout <= mem[rptr_next[AW-1:0]];
         end
      end
   end

endmodule

// File: rtl/triangle_stream_merger.sv
// Merges N_CH projector lane streams into one registered triangle stream with
// round-robin arbitration and a single end-of-frame pulse per frame.
module triangle_stream_merger
   import projector_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int TRI_W = TRI_W_DEFAULT,
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH*TRI_W-1:0] in_triangle,
   input  logic [N_CH-1:0]       in_valid,
   output logic [N_CH-1:0]       in_ready,
   input  logic [N_CH-1:0]       in_done,
   output logic [TRI_W-1:0]      triangle,
   output logic                  triangle_valid,
   input  logic                  triangle_ready,
   output logic                  done_out,
   output logic [CNT_W-1:0]      tri_count,
   output logic [N_CH-1:0]       overflow
);

   localparam int LANE_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [N_CH-1:0]   fifo_full;
   logic [N_CH-1:0]   fifo_empty;
   logic [N_CH-1:0]   fifo_push;
   logic [N_CH-1:0]   fifo_pop;
   logic [TRI_W-1:0]  fifo_dout [N_CH];
   logic [LANE_W-1:0] rr;
   logic [LANE_W-1:0] grant;
   logic [LANE_W-1:0] cand;
   logic              any_pending;
   logic              load;
   logic              handshake;
   logic              frame_end;
   logic [N_CH-1:0]   done_seen;

   assign in_ready  = ~fifo_full;
   assign fifo_push = in_valid & ~fifo_full;
   assign handshake = triangle_valid && triangle_ready;
   assign load      = !triangle_valid || triangle_ready;

   generate
      for (genvar i = 0; i < N_CH; i++) begin : g_lane
         triangle_fifo #(
            .WIDTH (TRI_W),
            .DEPTH (DEPTH)
         ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (fifo_push[i]),
            .pop   (fifo_pop[i]),
            .din   (in_triangle[i*TRI_W +: TRI_W]),
            .dout  (fifo_dout[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i])
         );
      end
   endgenerate

   // Walk downward so the candidate closest to rr is the one left standing.
   always_comb begin
      grant       = rr;
      cand        = '0;
      any_pending = 1'b0;
      for (int off = N_CH - 1; off >= 0; off--) begin
         cand = LANE_W'((int'(rr) + off) % N_CH);
         if (!fifo_empty[cand]) begin
            grant       = cand;
            any_pending = 1'b1;
         end
      end
   end

   always_comb begin
      fifo_pop = '0;
      if (load && any_pending) begin
         fifo_pop[grant] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         triangle       <= '0;
         triangle_valid <= 1'b0;
         rr             <= '0;
      end else if (load) begin
         if (any_pending) begin
            triangle       <= fifo_dout[grant];
            triangle_valid <= 1'b1;
            rr             <= LANE_W'(next_lane(int'(grant), N_CH));
         end else begin
            triangle_valid <= 1'b0;
         end
      end
   end

   assign frame_end = (&done_seen) && (&fifo_empty) && !triangle_valid;

   // On frame end the old marks are dropped, but a done arriving that same cycle is kept for the next frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_seen <= '0;
         done_out  <= 1'b0;
         overflow  <= '0;
      end else begin
         done_out  <= frame_end;
         done_seen <= frame_end ? in_done : (done_seen | in_done);
         overflow  <= overflow | (in_valid & fifo_full);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tri_count <= '0;
      end else if (done_out) begin
         tri_count <= '0;
      end else if (handshake && (tri_count != '1)) begin
         tri_count <= tri_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_triangle_stream_merger.sv
// Directed self-checking bench for triangle_stream_merger (N_CH=4, TRI_W=128, DEPTH=8).
module tb_triangle_stream_merger;

   logic         clk;
   logic         rst;
   logic [511:0] in_triangle;
   logic [3:0]   in_valid;
   logic [3:0]   in_ready;
   logic [3:0]   in_done;
   logic [127:0] triangle;
   logic         triangle_valid;
   logic         triangle_ready;
   logic         done_out;
   logic [15:0]  tri_count;
   logic [3:0]   overflow;

   int checkCount = 0;
   int errorCount = 0;
   int doneCount  = 0;
   int doneBase;

   typedef struct packed {
      logic [3:0]   valid;
      logic [127:0] data0;
      logic         ready;
      logic         expValid;
      logic [127:0] expTri;
      logic [15:0]  expCount;
   } vec_t;

   vec_t s1 [6];

   triangle_stream_merger #(
      .N_CH  (4),
      .TRI_W (128),
      .DEPTH (8),
      .CNT_W (16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .in_triangle    (in_triangle),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_done        (in_done),
      .triangle       (triangle),
      .triangle_valid (triangle_valid),
      .triangle_ready (triangle_ready),
      .done_out       (done_out),
      .tri_count      (tri_count),
      .overflow       (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done_out === 1'b1) doneCount++;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [127:0] mkWord(input int lane, input int idx);
      return {16'hBEEF, 8'(lane), 8'(idx), 96'h0123456789ABCDEF0F1E2D3C};
   endfunction

   function automatic logic [511:0] packLanes(input logic [127:0] w0, input logic [127:0] w1,
                                              input logic [127:0] w2, input logic [127:0] w3);
      return {w3, w2, w1, w0};
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checkCount++;
      if (act !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drives one cycle of inputs just after the rising edge, then returns at the falling edge for sampling.
   task automatic applyStimulus(input logic [3:0] v, input logic [511:0] d, input logic [3:0] dn,
                                input logic rdy);
      in_valid       = v;
      in_triangle    = d;
      in_done        = dn;
      triangle_ready = rdy;
      @(negedge clk);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst            = 1'b0;
      in_valid       = '0;
      in_triangle    = '0;
      in_done        = '0;
      triangle_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic laneWords(input int idx, output logic [511:0] d);
      d = packLanes(mkWord(0, idx), mkWord(1, idx), mkWord(2, idx), mkWord(3, idx));
   endtask

   initial begin
      logic [511:0] d;

      rst            = 1'b1;
      in_valid       = '0;
      in_triangle    = '0;
      in_done        = '0;
      triangle_ready = 1'b0;

      $display("[TB] reset values");
      #2 rst = 1'b0;
      #1;
      checkOutput("rst_triangle", triangle, 128'h0);
      checkOutput("rst_valid", 128'(triangle_valid), 128'h0);
      checkOutput("rst_done_out", 128'(done_out), 128'h0);
      checkOutput("rst_tri_count", 128'(tri_count), 128'h0);
      checkOutput("rst_overflow", 128'(overflow), 128'h0);
      checkOutput("rst_in_ready", 128'(in_ready), 128'hF);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      $display("[TB] single lane A,B,C with ready high");
      s1[0] = '{valid: 4'b0001, data0: mkWord(0, 10), ready: 1'b1, expValid: 1'b0, expTri: '0,             expCount: 16'd0};
      s1[1] = '{valid: 4'b0001, data0: mkWord(0, 11), ready: 1'b1, expValid: 1'b0, expTri: '0,             expCount: 16'd0};
      s1[2] = '{valid: 4'b0001, data0: mkWord(0, 12), ready: 1'b1, expValid: 1'b1, expTri: mkWord(0, 10), expCount: 16'd0};
      s1[3] = '{valid: 4'b0000, data0: '0,            ready: 1'b1, expValid: 1'b1, expTri: mkWord(0, 11), expCount: 16'd1};
      s1[4] = '{valid: 4'b0000, data0: '0,            ready: 1'b1, expValid: 1'b1, expTri: mkWord(0, 12), expCount: 16'd2};
      s1[5] = '{valid: 4'b0000, data0: '0,            ready: 1'b1, expValid: 1'b0, expTri: '0,             expCount: 16'd3};
      for (int i = 0; i < 6; i++) begin
         applyStimulus(s1[i].valid, {384'h0, s1[i].data0}, 4'b0000, s1[i].ready);
         checkOutput("s1_valid", 128'(triangle_valid), 128'(s1[i].expValid));
         if (s1[i].expValid) checkOutput("s1_triangle", triangle, s1[i].expTri);
         checkOutput("s1_tri_count", 128'(tri_count), 128'(s1[i].expCount));
         nextCycle();
      end

      $display("[TB] four-lane preload, stall, round-robin drain");
      doReset();
      laneWords(0, d);
      applyStimulus(4'hF, d, 4'h0, 1'b0);
      checkOutput("s2_valid_c0", 128'(triangle_valid), 128'h0);
      nextCycle();
      laneWords(1, d);
      applyStimulus(4'hF, d, 4'h0, 1'b0);
      checkOutput("s2_valid_c1", 128'(triangle_valid), 128'h0);
      nextCycle();
      for (int s = 0; s < 5; s++) begin
         applyStimulus(4'h0, '0, 4'h0, 1'b0);
         checkOutput("stall_valid", 128'(triangle_valid), 128'h1);
         checkOutput("stall_triangle", triangle, mkWord(0, 0));
         nextCycle();
      end
      for (int j = 0; j < 8; j++) begin
         applyStimulus(4'h0, '0, 4'h0, 1'b1);
         checkOutput("rr_valid", 128'(triangle_valid), 128'h1);
         checkOutput("rr_triangle", triangle, mkWord(j % 4, j / 4));
         nextCycle();
      end
      applyStimulus(4'h0, '0, 4'h0, 1'b1);
      checkOutput("rr_drained", 128'(triangle_valid), 128'h0);
      checkOutput("rr_tri_count", 128'(tri_count), 128'd8);
      nextCycle();

      $display("[TB] lane 0 overflow");
      doReset();
      for (int k = 0; k < 11; k++) begin
         applyStimulus(4'b0001, packLanes(mkWord(0, k + 1), '0, '0, '0), 4'h0, 1'b0);
         checkOutput("ovf_in_ready0", 128'(in_ready[0]), 128'(k < 9));
         checkOutput("ovf_flag0", 128'(overflow[0]), 128'(k >= 10));
         nextCycle();
      end
      applyStimulus(4'h0, '0, 4'h0, 1'b0);
      checkOutput("ovf_in_ready", 128'(in_ready), 128'hE);
      checkOutput("ovf_overflow", 128'(overflow), 128'h1);
      nextCycle();
      for (int k = 0; k < 9; k++) begin
         applyStimulus(4'h0, '0, 4'h0, 1'b1);
         checkOutput("ovf_drain_valid", 128'(triangle_valid), 128'h1);
         checkOutput("ovf_drain_triangle", triangle, mkWord(0, k + 1));
         nextCycle();
      end
      applyStimulus(4'h0, '0, 4'h0, 1'b1);
      checkOutput("ovf_drain_empty", 128'(triangle_valid), 128'h0);
      checkOutput("ovf_tri_count", 128'(tri_count), 128'd9);
      nextCycle();

      $display("[TB] frame end with staggered done pulses");
      doReset();
      doneBase = doneCount;
      laneWords(0, d);
      applyStimulus(4'hF, d, 4'h0, 1'b0);
      nextCycle();
      laneWords(1, d);
      applyStimulus(4'h3, d, 4'b0001, 1'b0);
      nextCycle();
      applyStimulus(4'h0, '0, 4'b0110, 1'b0);
      nextCycle();
      applyStimulus(4'h0, '0, 4'b1000, 1'b0);
      checkOutput("fe_no_early_done", 128'(done_out), 128'h0);
      nextCycle();
      applyStimulus(4'h0, '0, 4'b0100, 1'b0);
      nextCycle();
      for (int j = 0; j < 6; j++) begin
         applyStimulus(4'h0, '0, 4'h0, 1'b1);
         checkOutput("fe_triangle", triangle, mkWord(j % 4, j / 4));
         checkOutput("fe_tri_count", 128'(tri_count), 128'(j));
         checkOutput("fe_done_low", 128'(done_out), 128'h0);
         nextCycle();
      end
      applyStimulus(4'h0, '0, 4'h0, 1'b1);
      checkOutput("fe_valid_after", 128'(triangle_valid), 128'h0);
      checkOutput("fe_done_h1", 128'(done_out), 128'h0);
      nextCycle();
      applyStimulus(4'h0, '0, 4'h0, 1'b1);
      checkOutput("fe_done_h2", 128'(done_out), 128'h1);
      checkOutput("fe_count_at_done", 128'(tri_count), 128'd6);
      nextCycle();
      applyStimulus(4'h0, '0, 4'h0, 1'b1);
      checkOutput("fe_done_h3", 128'(done_out), 128'h0);
      checkOutput("fe_count_cleared", 128'(tri_count), 128'd0);
      nextCycle();
      checkOutput("fe_done_pulses", 128'(doneCount - doneBase), 128'd1);

      $display("[TB] asynchronous reset mid-stream");
      doReset();
      laneWords(0, d);
      applyStimulus(4'hF, d, 4'h0, 1'b0);
      nextCycle();
      laneWords(1, d);
      applyStimulus(4'hF, d, 4'hF, 1'b0);
      nextCycle();
      applyStimulus(4'h0, '0, 4'h0, 1'b1);
      nextCycle();
      applyStimulus(4'h0, '0, 4'h0, 1'b0);
      checkOutput("ar_pre_triangle", triangle, mkWord(1, 0));
      checkOutput("ar_pre_count", 128'(tri_count), 128'd1);
      #2 rst = 1'b0;
      #1;
      checkOutput("ar_triangle", triangle, 128'h0);
      checkOutput("ar_valid", 128'(triangle_valid), 128'h0);
      checkOutput("ar_tri_count", 128'(tri_count), 128'h0);
      checkOutput("ar_done_out", 128'(done_out), 128'h0);
      checkOutput("ar_in_ready", 128'(in_ready), 128'hF);
      checkOutput("ar_overflow", 128'(overflow), 128'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      doneBase = doneCount;
      for (int k = 0; k < 10; k++) begin
         applyStimulus(4'h0, '0, 4'h0, 1'b1);
         checkOutput("ar_post_valid", 128'(triangle_valid), 128'h0);
         checkOutput("ar_post_done", 128'(done_out), 128'h0);
         nextCycle();
      end
      checkOutput("ar_post_pulses", 128'(doneCount - doneBase), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/triangle_stream_merger.md
# triangle_stream_merger

Merges the triangle streams of `N_CH` parallel projector lanes into the single triangle stream consumed by the rasteriser, so obstacle projection can be spread over several lanes. Each lane feeds a per-channel FIFO. A round-robin arbiter drains the FIFOs into one registered output with valid/ready backpressure. The block emits a single end-of-frame `done_out` once every lane has signalled done and every buffered triangle has been handed off.

## Interface
- `N_CH`, 4: number of input lanes, 1..8.
- `TRI_W`, 128: triangle word width.
- `DEPTH`, 8: per-lane FIFO depth, power of two, ≥2.
- `CNT_W`, 16: width of the frame triangle counter.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `in_triangle`  in  N_CH*TRI_W  lane i occupies bits [i*TRI_W +: TRI_W].
- `in_valid`  in  N_CH  per-lane triangle valid.
- `in_ready`  out  N_CH  per-lane FIFO not full.
- `in_done`  in  N_CH  per-lane end-of-frame pulse.
- `triangle`  out  TRI_W  merged triangle.
- `triangle_valid`  out  1  output valid.
- `triangle_ready`  in  1  downstream accepts.
- `done_out`  out  1  one-cycle end-of-frame pulse.
- `tri_count`  out  CNT_W  output handshakes in the current frame.
- `overflow`  out  N_CH  sticky per-lane drop flag.

## Operation
- Accept on lane i when `in_valid[i] && in_ready[i]`; the word is pushed into FIFO i.
- `in_ready[i] = ~full[i]`. It is not pop-aware.
- `in_valid[i]` while `in_ready[i]=0` drops the beat and sets `overflow[i]`. The flag clears only on reset.
- Arbiter: rotating pointer `rr`, 0 after reset.
  - The arbiter selects the first non-empty FIFO searching from `rr` upward, mod `N_CH`.
  - After granting lane k, `rr` becomes k+1 mod `N_CH`.
- Output register loads (pop + grant) when it is empty, or when it holds a word and `triangle_ready=1` that cycle.
- `triangle` and `triangle_valid` stay stable while `triangle_valid && !triangle_ready`.
- Done tracking:
  - `in_done[i]` sets `done_seen[i]`. A repeat pulse while the bit is already set is ignored.
  - A beat accepted in the same cycle as its lane's done belongs to the current frame.
- Frame end condition: all `done_seen` set, all FIFOs empty, and output register empty (last word handshaken). When it holds:
  - `done_out` pulses the next cycle.
  - `done_seen` clears in that same cycle.
- `tri_count` increments on each output handshake and saturates at 2^CNT_W−1.
  - It holds the frame total during the `done_out` cycle.
  - It reads 0 the cycle after.
  - A handshake in the `done_out` cycle is impossible, because the output register is empty.
- Reset, async assert at any time, including mid-frame: FIFOs flushed, `rr`=0, `done_seen`=0; no `done_out` is produced for the aborted frame.

## Timing
- Reset values:
  - `triangle`=0, `triangle_valid`=0, `done_out`=0, `tri_count`=0, `overflow`=0.
  - `in_ready`=all 1 (FIFOs empty).
- Latency: accept at edge t into an empty FIFO with empty output gives `triangle_valid` in cycle t+2. There is no bypass path.
- Throughput: one triangle per cycle sustained while `triangle_ready=1`.
- `done_out` follows the final output handshake by 2 cycles at minimum (register empties, condition registered).
- Full-FIFO push refusal: `in_ready` drops in the cycle after the `DEPTH`-th word is held. A pop that cycle does not re-raise it until the next cycle.
- Simultaneous push/pop on the same FIFO: both take effect, occupancy unchanged.

## Structure
- Package `projector_pkg`: `TRI_W` default constant, `triangle_t` typedef (`logic [TRI_W-1:0]`). The package is shared with the projector lanes.
- Sub-module `triangle_fifo` (params `WIDTH`, `DEPTH`):
  - Ports: push, pop, din, dout, full, empty.
  - Synchronous-read register array, pointers one bit wider than log2(`DEPTH`) for full/empty.
  - Instantiated `N_CH` times via generate.
- Arbiter, output register, done tracker and counter are in the top module.

## Test plan
- Lane 0 pushes A,B,C back-to-back with `triangle_ready=1`: output is A,B,C; first `triangle_valid` 2 cycles after A accepted; `tri_count`=3.
- Lanes 0–3 each preload 2 words with `triangle_ready=0`, then ready=1: output order L0,L1,L2,L3,L0,L1,L2,L3, one per cycle.
- `DEPTH`=8, ready=0, lane 0 drives valid for 11 cycles:
  - 9 accepted (1 in output register + 8 in FIFO).
  - `in_ready[0]`=0 afterwards.
  - `overflow[0]`=1 from the 10th beat; `overflow[1..3]`=0.
- Stall ready=0 for 5 cycles with `triangle_valid`=1: `triangle` unchanged across all 5 cycles, nothing lost.
- Frame end:
  - Lanes pulse done at different cycles with 6 words still buffered, lane 2 pulses done twice.
  - Exactly one `done_out`, 2 cycles after the 6th handshake; `tri_count` holds the total that cycle, then 0.
- `rst`=0 mid-stream with all FIFOs part-full:
  - Outputs go to reset values immediately (async); `in_ready` all 1.
  - After release with no new input: no `triangle_valid`, no `done_out`.
